yuv_ctrl: RTL and testbench
===========================

YUV_CTRL -- requirements
Module: yuv_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the completed-pixel counter.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  a pixel request; the RGB pixel on the datapath inports is held stable from the accept cycle through the following LOAD cycle.
REQ-005 clr_cnt  input  1  synchronous clear of pix_cnt.
REQ-006 ready  output  1  high in IDLE and DONE states; start is accepted only when ready=1.
REQ-007 busy  output  1  high in states LOAD through SUM_V.
REQ-008 control  output  15  datapath control word: [14:7] load enables R1..R8; [6:5] coefficient ROM address; [4] M1 select; [3] M2 select; [2] M3 select; [1] M4 select; [0] M5 select (select 1 picks the adder-result input).
REQ-009 done  output  1  one-cycle strobe that captures R1/R6/R2 into the Y/U/V output registers.
REQ-010 out_valid  output  1  one-cycle strobe, high the cycle after done, when the Y/U/V outputs are valid.
REQ-011 pix_cnt  output  CNT_W  count of completed pixels.

Function
REQ-012 The FSM SHALL be 3-bit encoded: IDLE=0, LOAD=1, MUL_Y=2, ADD_Y=3, SUM_Y=4, SUM_U=5, SUM_V=6, DONE=7.
REQ-013 control SHALL be a Moore decode of state: IDLE 15'h0000, LOAD 15'h7000, MUL_Y 15'h0E20, ADD_Y 15'h0DC0, SUM_Y 15'h5DCA, SUM_U 15'h1313, SUM_V 15'h2014, DONE 15'h0000.
REQ-014 ROM address SHALL lead its use by one cycle (registered ROM): Y coefficients (addr 0) in LOAD, U (addr 1) in MUL_Y, V (addr 2) in ADD_Y and SUM_Y, addr 0 elsewhere.
REQ-015 Transitions: IDLE->LOAD on start; LOAD->MUL_Y->ADD_Y->SUM_Y->SUM_U->SUM_V->DONE unconditionally; DONE->LOAD on start, otherwise DONE->IDLE.
REQ-016 start SHALL be ignored while busy=1; no queuing and no error flag.
REQ-017 Latency: start accepted in cycle n; LOAD n+1; DONE (done=1) n+7; out_valid=1 at n+8.
REQ-018 Back-to-back starts accepted in DONE SHALL sustain one pixel per 7 cycles with no IDLE cycle inserted.
REQ-019 done SHALL equal (state==DONE); out_valid SHALL be done delayed one cycle through a register.
REQ-020 pix_cnt SHALL increment by 1 at the end of each DONE cycle and wrap from 2^CNT_W-1 to 0.
REQ-021 clr_cnt SHALL zero pix_cnt on the next edge and win over a simultaneous increment.
REQ-022 No combinational path SHALL exist from start to control; control, done, ready and busy depend on state only.

Reset
REQ-023 rst_n low SHALL force, asynchronously: state=IDLE, control=0, done=0, out_valid=0, pix_cnt=0, ready=1, busy=0.
REQ-024 Reset asserted mid-pixel SHALL abort the pixel with no done or out_valid pulse; the first start after release SHALL begin a fresh LOAD.

Verification
REQ-025 Single pixel: start=1 for one cycle in IDLE at cycle 0 -> control sequence 7000,0E20,0DC0,5DCA,1313,2014,0000 on cycles 1-7; done=1 on cycle 7; out_valid=1 on cycle 8; pix_cnt=1 on cycle 8.
REQ-026 Datapath co-simulation with R=255, G=0, B=0 -> Y/U/V outputs match the fixed-point reference model on the out_valid cycle.
REQ-027 Start held high continuously for 3 pixels -> done on cycles 7, 14 and 21; no IDLE state between pixels; pix_cnt=3.
REQ-028 start pulsed during SUM_Y -> ignored; exactly one done pulse; ready=0 throughout cycles 1-6.
REQ-029 rst_n low during SUM_U -> control=0 immediately; no done pulse; pix_cnt=0; a subsequent start completes normally.
REQ-030 pix_cnt preset to 16'hFFFF by counting, then one more pixel -> 16'h0000; clr_cnt asserted in the DONE cycle -> pix_cnt=0, not 1.

Source files
------------

// File: rtl/yuv_ctrl_if.sv
// Handshake and status bundle between the RGB->YUV pixel controller and its requester.
// master drives requests; slave is the controller side.
interface yuv_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             clr_cnt;
  logic             ready;
  logic             busy;
  logic [14:0]      control;
  logic             done;
  logic             out_valid;
  logic [CNT_W-1:0] pix_cnt;

  modport master (
    output start, clr_cnt,
    input  ready, busy, control, done, out_valid, pix_cnt
  );

  modport slave (
    input  start, clr_cnt,
    output ready, busy, control, done, out_valid, pix_cnt
  );
endinterface

// File: rtl/yuv_ctrl.sv
// Sequencer for the RGB->YUV datapath: one pixel per 7 cycles, Moore control word,
// done/out_valid strobes and a wrapping completed-pixel counter.
module yuv_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  yuv_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL_Y = 3'd2,
    ADD_Y = 3'd3,
    SUM_Y = 3'd4,
    SUM_U = 3'd5,
    SUM_V = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t           state, state_nxt;
  logic [14:0]      control;
  logic             out_valid_q;
  logic [CNT_W-1:0] pix_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Start is only looked at in IDLE/DONE, so it is ignored while busy.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = bus.start ? LOAD : IDLE;
      LOAD:    state_nxt = MUL_Y;
      MUL_Y:   state_nxt = ADD_Y;
      ADD_Y:   state_nxt = SUM_Y;
      SUM_Y:   state_nxt = SUM_U;
      SUM_U:   state_nxt = SUM_V;
      SUM_V:   state_nxt = DONE;
      DONE:    state_nxt = bus.start ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ROM address in [6:5] runs one state ahead of the stage consuming the coefficient.
  always_comb begin
    control = '0;
    unique case (state)
      LOAD:    control = 15'h7000;
      MUL_Y:   control = 15'h0E20;
      ADD_Y:   control = 15'h0DC0;
      SUM_Y:   control = 15'h5DCA;
      SUM_U:   control = 15'h1313;
      SUM_V:   control = 15'h2014;
      default: control = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      pix_cnt_q   <= '0;
    end else begin
      out_valid_q <= (state == DONE);
      if (bus.clr_cnt)        pix_cnt_q <= '0;
      else if (state == DONE) pix_cnt_q <= pix_cnt_q + 1'b1;
    end
  end

  assign bus.control   = control;
  assign bus.ready     = (state == IDLE) || (state == DONE);
  assign bus.busy      = (state != IDLE) && (state != DONE);
  assign bus.done      = (state == DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.pix_cnt   = pix_cnt_q;

endmodule

// File: tb/tb_yuv_ctrl.sv
// Directed plus random bench for yuv_ctrl against a cycles-into-pixel reference model.
module tb_yuv_ctrl;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  yuv_ctrl_if #(.CNT_W(CNT_W)) bus ();
  yuv_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          done_seen = 0;
  // Model: m_step = cycles into the current pixel (0 = no pixel, 1..7 = LOAD..DONE).
  int          m_step = 0;
  int unsigned m_cnt  = 0;
  logic        m_ov   = 1'b0;

  function automatic logic [14:0] exp_ctl(input int step);
    case (step)
      1:       return 15'h7000;
      2:       return 15'h0E20;
      3:       return 15'h0DC0;
      4:       return 15'h5DCA;
      5:       return 15'h1313;
      6:       return 15'h2014;
      default: return 15'h0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("control",   32'(bus.control),   32'(exp_ctl(m_step)));
    chk("ready",     32'(bus.ready),     32'(m_step == 0 || m_step == 7));
    chk("busy",      32'(bus.busy),      32'(m_step >= 1 && m_step <= 6));
    chk("done",      32'(bus.done),      32'(m_step == 7));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("pix_cnt",   32'(bus.pix_cnt),   m_cnt);
  endtask

  task automatic cycle(input logic s, input logic c);
    bus.start   = s;
    bus.clr_cnt = c;
    @(posedge clk);
    #1;
    if (rst_n) begin
      m_ov  = (m_step == 7);
      if (c)                m_cnt = 0;
      else if (m_step == 7) m_cnt = (m_cnt + 1) % (32'd1 << CNT_W);
      if (m_step == 0 || m_step == 7) m_step = s ? 1 : 0;
      else                            m_step = m_step + 1;
    end
    if (bus.done) done_seen++;
    check_all();
  endtask

  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    m_step = 0;
    m_cnt  = 0;
    m_ov   = 1'b0;
    check_all();
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.clr_cnt = 1'b0;
    #12;
    check_all();
    rst_n = 1'b1;

    // Single pixel from IDLE.
    done_seen = 0;
    cycle(1'b1, 1'b0);
    repeat (7) cycle(1'b0, 1'b0);
    chk("single_done_cnt", done_seen, 1);
    chk("single_pix_cnt", 32'(bus.pix_cnt), 1);

    // Start held high for three pixels.
    cycle(1'b0, 1'b1);
    done_seen = 0;
    repeat (15) cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    chk("b2b_done_cnt", done_seen, 3);
    chk("b2b_pix_cnt", 32'(bus.pix_cnt), 3);

    // Start pulsed during SUM_Y is ignored.
    done_seen = 0;
    cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b0);
    chk("ignored_done_cnt", done_seen, 1);
    chk("ignored_pix_cnt", 32'(bus.pix_cnt), 4);

    // Reset during SUM_U aborts the pixel; next start runs cleanly.
    done_seen = 0;
    cycle(1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b0);
    chk("pre_reset_ctl", 32'(bus.control), 32'h1313);
    async_reset();
    chk("reset_ctl_zero", 32'(bus.control), 0);
    repeat (2) cycle(1'b1, 1'b0);
    rst_n = 1'b1;
    chk("abort_no_done", done_seen, 0);
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    chk("post_reset_done", done_seen, 1);
    chk("post_reset_cnt", 32'(bus.pix_cnt), 1);

    // Random start / clear traffic.
    repeat (400) cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    repeat (8) cycle(1'b0, 1'b0);

    // Fill the counter to its maximum, then wrap.
    cycle(1'b0, 1'b1);
    repeat ((2 ** CNT_W - 2) * 7 + 1) cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    chk("cnt_max", 32'(bus.pix_cnt), 2 ** CNT_W - 1);
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    chk("cnt_wrap", 32'(bus.pix_cnt), 0);
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    chk("cnt_after_wrap", 32'(bus.pix_cnt), 1);

    // Clear in the DONE cycle beats the increment.
    cycle(1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b0);
    chk("at_done", 32'(bus.done), 1);
    cycle(1'b0, 1'b1);
    chk("clr_wins", 32'(bus.pix_cnt), 0);
    repeat (2) cycle(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
